// File: rtl/tick_pkg.sv
// Shared types and default timing constants for the game tick scheduler.
package tick_pkg;

    localparam int unsigned LEVEL_W = 3;

    localparam int unsigned SHIP_PERIOD_DEF       = 200_000;
    localparam int unsigned PROJ_PERIOD_DEF       = 1_000_000;
    localparam int unsigned ALIEN_BASE_PERIOD_DEF = 6_000_000;
    localparam int unsigned ALIEN_STEP_DEF        = 500_000;
    localparam int unsigned COOLDOWN_PERIOD_DEF   = 200_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // Alien period for a given level; product kept at full 32-bit width
    function automatic int unsigned alien_period(input int unsigned base,
                                                 input int unsigned step,
                                                 input logic [LEVEL_W-1:0] lvl);
        return base - (32'(lvl) * step);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between the top level and the tick scheduler.
interface tick_scheduler_if;
    import tick_pkg::*;

    logic               start;
    logic               pause;
    logic [LEVEL_W-1:0] level;
    logic               fire_req;
    logic               fire_grant;
    logic               cooldown_busy;
    logic               tick_ship;
    logic               tick_proj;
    logic               tick_alien;
    logic               pix_en;
    state_e             state;

    modport master (
        output start, pause, level, fire_req,
        input  fire_grant, cooldown_busy, tick_ship, tick_proj, tick_alien, pix_en, state
    );

    modport slave (
        input  start, pause, level, fire_req,
        output fire_grant, cooldown_busy, tick_ship, tick_proj, tick_alien, pix_en, state
    );

endinterface

// File: rtl/tick_counter.sv
// Period counter with a registered one-cycle wrap strobe; the period is
// re-latched while cleared and at every wrap, so changes apply to the next period.
module tick_counter #(
    parameter int unsigned W          = 8,
    parameter int unsigned RST_PERIOD = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W:0]   period_i,
    output logic         tick_o
);

    localparam int unsigned PW = W + 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] last_q, last_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d  = '0;
            last_d = W'(period_i - PW'(1));
        end else if (en_i) begin
            if (cnt_q == last_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                last_d = W'(period_i - PW'(1));
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            last_q <= W'(RST_PERIOD - 1);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// Game timing: run/pause FSM gating ship/projectile/alien tick strobes,
// fire-request arbitration with cooldown, and a free-running pixel enable.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int unsigned SHIP_PERIOD       = SHIP_PERIOD_DEF,
    parameter int unsigned PROJ_PERIOD       = PROJ_PERIOD_DEF,
    parameter int unsigned ALIEN_BASE_PERIOD = ALIEN_BASE_PERIOD_DEF,
    parameter int unsigned ALIEN_STEP        = ALIEN_STEP_DEF,
    parameter int unsigned COOLDOWN_PERIOD   = COOLDOWN_PERIOD_DEF
) (
    input  logic           master_clk,
    input  logic           RESET_debounced,
    tick_scheduler_if.slave bus
);

    localparam int unsigned MAX_P = max3(SHIP_PERIOD, PROJ_PERIOD, ALIEN_BASE_PERIOD);
    localparam int unsigned CNT_W = $clog2(MAX_P);
    localparam int unsigned PER_W = CNT_W + 1;
    localparam int unsigned CD_W  = $clog2(COOLDOWN_PERIOD);

    localparam logic [CD_W-1:0]  CD_LAST    = CD_W'(COOLDOWN_PERIOD - 1);
    localparam logic [PER_W-1:0] SHIP_PER   = PER_W'(SHIP_PERIOD);
    localparam logic [PER_W-1:0] PROJ_PER   = PER_W'(PROJ_PERIOD);

    state_e            state_q, state_d;
    logic              fire_grant_q, fire_grant_d;
    logic              busy_q, busy_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic [1:0]        pix_cnt_q, pix_cnt_d;
    logic              pix_en_q, pix_en_d;

    logic              run;
    logic              idle;
    logic [PER_W-1:0]  alien_per;
    logic              tick_ship, tick_proj, tick_alien;

    assign run       = (state_q == ST_RUN);
    assign idle      = (state_q == ST_IDLE);
    assign alien_per = PER_W'(alien_period(ALIEN_BASE_PERIOD, ALIEN_STEP, bus.level));

    // Next state, fire arbitration and pixel divider
    always_comb begin
        state_d      = state_q;
        fire_grant_d = 1'b0;
        busy_d       = busy_q;
        cd_d         = cd_q;
        pix_cnt_d    = pix_cnt_q + 2'd1;
        pix_en_d     = (pix_cnt_q == 2'd3);

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                cd_d   = '0;
                if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.pause) begin
                    state_d = ST_PAUSE;
                end
                // Requests arriving while busy are dropped, never queued
                if (busy_q) begin
                    if (cd_q == CD_LAST) begin
                        busy_d = 1'b0;
                        cd_d   = '0;
                    end else begin
                        cd_d = cd_q + CD_W'(1);
                    end
                end else if (bus.fire_req) begin
                    fire_grant_d = 1'b1;
                    busy_d       = 1'b1;
                    cd_d         = '0;
                end
            end
            ST_PAUSE: begin
                if (!bus.pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge master_clk or posedge RESET_debounced) begin
        if (RESET_debounced) begin
            state_q      <= ST_IDLE;
            fire_grant_q <= 1'b0;
            busy_q       <= 1'b0;
            cd_q         <= '0;
            pix_cnt_q    <= '0;
            pix_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fire_grant_q <= fire_grant_d;
            busy_q       <= busy_d;
            cd_q         <= cd_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_en_q     <= pix_en_d;
        end
    end

    tick_counter #(.W(CNT_W), .RST_PERIOD(SHIP_PERIOD)) u_ship (
        .clk_i    (master_clk),
        .rst_i    (RESET_debounced),
        .en_i     (run),
        .clr_i    (idle),
        .period_i (SHIP_PER),
        .tick_o   (tick_ship)
    );

    tick_counter #(.W(CNT_W), .RST_PERIOD(PROJ_PERIOD)) u_proj (
        .clk_i    (master_clk),
        .rst_i    (RESET_debounced),
        .en_i     (run),
        .clr_i    (idle),
        .period_i (PROJ_PER),
        .tick_o   (tick_proj)
    );

    // Alien period latched on IDLE->RUN and at every wrap from the live level
    tick_counter #(.W(CNT_W), .RST_PERIOD(ALIEN_BASE_PERIOD)) u_alien (
        .clk_i    (master_clk),
        .rst_i    (RESET_debounced),
        .en_i     (run),
        .clr_i    (idle),
        .period_i (alien_per),
        .tick_o   (tick_alien)
    );

    assign bus.state         = state_q;
    assign bus.fire_grant    = fire_grant_q;
    assign bus.cooldown_busy = busy_q;
    assign bus.pix_en        = pix_en_q;
    assign bus.tick_ship     = tick_ship;
    assign bus.tick_proj     = tick_proj;
    assign bus.tick_alien    = tick_alien;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with shortened periods and hand-derived timings.
module tb_tick_scheduler;
    import tick_pkg::*;

    localparam int unsigned SHIP_P = 10;
    localparam int unsigned PROJ_P = 50;
    localparam int unsigned ABASE  = 64;
    localparam int unsigned ASTEP  = 8;
    localparam int unsigned CD_P   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tick_scheduler_if bus();

    tick_scheduler #(
        .SHIP_PERIOD       (SHIP_P),
        .PROJ_PERIOD       (PROJ_P),
        .ALIEN_BASE_PERIOD (ABASE),
        .ALIEN_STEP        (ASTEP),
        .COOLDOWN_PERIOD   (CD_P)
    ) dut (
        .master_clk      (clk),
        .RESET_debounced (rst),
        .bus             (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0, f0, at, a0, a1, a2, a3;
    int bad, pixn, pixbad, pcnt, tbad, gn;
    int n_t[3], first_t[3], last_t[3], gbad[3], gap_e[3];
    int g_at[3];
    logic busy_h[0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic pulse(input int which);
        case (which)
            0:       return bus.tick_ship;
            1:       return bus.tick_proj;
            2:       return bus.tick_alien;
            default: return bus.fire_grant;
        endcase
    endfunction

    function automatic logic [7:0] all_out();
        return {bus.tick_ship, bus.tick_proj, bus.tick_alien, bus.fire_grant,
                bus.cooldown_busy, bus.pix_en, bus.state};
    endfunction

    task automatic wait_pulse(input string tag, input int which, input int limit, output int t);
        logic seen;
        seen = 1'b0;
        t    = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (pulse(which)) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.level    = '0;
        bus.fire_req = 1'b0;

        // Reset, then 100 idle cycles
        #2;
        chk("rst_outputs", 32'(all_out()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        bad = 0; pixn = 0; pixbad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ((all_out() & 8'b1111_1011) != 8'd0) bad++;
            if (bus.pix_en) begin
                pixn++;
                if (cyc % 4 != 0) pixbad++;
            end
        end
        chk("idle_quiet", 32'(bad), 32'd0);
        chk("idle_pix_count", 32'(pixn), 32'd25);
        chk("idle_pix_phase", 32'(pixbad), 32'd0);

        // Tick spacing at level 0
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("run_entry", 32'(bus.state), 32'd1);
        t0 = cyc;
        gap_e[0] = SHIP_P; gap_e[1] = PROJ_P; gap_e[2] = ABASE;
        for (int k = 0; k < 3; k++) begin
            n_t[k] = 0; first_t[k] = 0; last_t[k] = 0; gbad[k] = 0;
        end
        gn = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                if (pulse(k)) begin
                    if (n_t[k] == 0) first_t[k] = cyc - t0;
                    else if (cyc - last_t[k] != gap_e[k]) gbad[k]++;
                    last_t[k] = cyc;
                    n_t[k]++;
                end
            end
            if (bus.fire_grant) gn++;
        end
        chk("ship_count", 32'(n_t[0]), 32'd20);
        chk("ship_first", 32'(first_t[0]), 32'd10);
        chk("ship_gap", 32'(gbad[0]), 32'd0);
        chk("proj_count", 32'(n_t[1]), 32'd4);
        chk("proj_first", 32'(first_t[1]), 32'd50);
        chk("proj_gap", 32'(gbad[1]), 32'd0);
        chk("alien_count", 32'(n_t[2]), 32'd3);
        chk("alien_first", 32'(first_t[2]), 32'd64);
        chk("alien_gap", 32'(gbad[2]), 32'd0);
        chk("no_grant_run", 32'(gn), 32'd0);

        // Pause for 37 cycles with the ship counter at 4..5
        repeat (4) step();
        bus.pause = 1'b1;
        step();
        chk("pause_entry", 32'(bus.state), 32'd2);
        pcnt = 1; tbad = 0;
        for (int i = 0; i < 36; i++) begin
            step();
            if (bus.state == ST_PAUSE) pcnt++;
            if (bus.tick_ship || bus.tick_proj || bus.tick_alien) tbad++;
        end
        bus.pause = 1'b0;
        chk("pause_cycles", 32'(pcnt), 32'd37);
        chk("pause_no_ticks", 32'(tbad), 32'd0);
        step();
        chk("resume_state", 32'(bus.state), 32'd1);
        wait_pulse("ship_resume", 0, 20, at);
        chk("ship_after_pause", 32'(at - t0), 32'd247);

        // Level change mid alien period
        wait_pulse("alien_a0", 2, 100, a0);
        chk("alien_after_pause", 32'(a0 - t0), 32'd293);
        repeat (20) step();
        bus.level = 3'd3;
        wait_pulse("alien_a1", 2, 100, a1);
        chk("alien_gap_current", 32'(a1 - a0), 32'd64);
        wait_pulse("alien_a2", 2, 100, a2);
        chk("alien_gap_lvl3_a", 32'(a2 - a1), 32'd40);
        wait_pulse("alien_a3", 2, 100, a3);
        chk("alien_gap_lvl3_b", 32'(a3 - a2), 32'd40);

        // Fire held for 60 cycles
        chk("busy_before_fire", 32'(bus.cooldown_busy), 32'd0);
        bus.fire_req = 1'b1;
        f0 = cyc;
        gn = 0;
        g_at[0] = 0; g_at[1] = 0; g_at[2] = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            busy_h[cyc - f0] = bus.cooldown_busy;
            if (bus.fire_grant) begin
                if (gn < 3) g_at[gn] = cyc - f0;
                gn++;
            end
        end
        chk("grant_count", 32'(gn), 32'd3);
        chk("grant_1", 32'(g_at[0]), 32'd1);
        chk("grant_2", 32'(g_at[1]), 32'd22);
        chk("grant_3", 32'(g_at[2]), 32'd43);
        chk("busy_r1", 32'(busy_h[1]), 32'd1);
        chk("busy_r20", 32'(busy_h[20]), 32'd1);
        chk("busy_r21", 32'(busy_h[21]), 32'd0);
        chk("busy_r41", 32'(busy_h[41]), 32'd1);
        chk("busy_r42", 32'(busy_h[42]), 32'd0);

        // Reset during a paused cooldown
        bus.fire_req = 1'b0;
        bus.pause    = 1'b1;
        step();
        chk("cd_pause_state", 32'(bus.state), 32'd2);
        repeat (2) step();
        chk("cd_pause_busy_hold", 32'(bus.cooldown_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'(all_out()), 32'd0);
        bus.pause    = 1'b0;
        bus.start    = 1'b1;
        bus.fire_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        bus.start = 1'b0;
        chk("restart_run", 32'(bus.state), 32'd1);
        chk("restart_no_grant_yet", 32'(bus.fire_grant), 32'd0);
        step();
        chk("restart_grant", 32'(bus.fire_grant), 32'd1);
        chk("restart_busy", 32'(bus.cooldown_busy), 32'd1);
        bus.fire_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Sequences the game's timing resources from the 100 MHz master clock: it produces single-cycle tick strobes for ship, projectile and alien update logic, plus a free-running 25 MHz pixel enable. It also arbitrates player fire requests against a cooldown timer. It sits between the top level and the game-object modules. A run/pause state machine gates all game ticks, and a speed level shortens the alien period.

## Interface
- SHIP_PERIOD, 200_000: master_clk cycles between tick_ship strobes (500 Hz)
- PROJ_PERIOD, 1_000_000: cycles between tick_proj strobes (100 Hz)
- ALIEN_BASE_PERIOD, 6_000_000: alien period at level 0
- ALIEN_STEP, 500_000: period reduction per level; must satisfy ALIEN_BASE_PERIOD > (2^LEVEL_W-1)*ALIEN_STEP
- COOLDOWN_PERIOD, 200_000_000: cycles cooldown_busy stays high after a grant (2 s)
- LEVEL_W, 3: width of level

Ports:
- master_clk  in  1  100 MHz system clock
- RESET_debounced  in  1  reset, asynchronous, active-high
- start  in  1  pulse; IDLE->RUN
- pause  in  1  level; high holds PAUSE
- level  in  LEVEL_W  alien speed level
- fire_req  in  1  player fire request (level or pulse)
- fire_grant  out  1  one-cycle grant pulse
- cooldown_busy  out  1  high while cooldown runs
- tick_ship, tick_proj, tick_alien  out  1 each  one-cycle strobes
- pix_en  out  1  one cycle in four
- state  out  2  IDLE=00, RUN=01, PAUSE=10

## Operation
- **Reset.** Asynchronous reset forces state=IDLE. It clears all counters to 0 and drives every output to 0. The alien period register loads ALIEN_BASE_PERIOD.
- **IDLE.**
  - Game counters and cooldown are held at 0.
  - No ticks and no grants are issued.
  - start=1 moves to RUN and latches the alien period from level.
  - pause is ignored in IDLE. start and pause high together in IDLE: start wins, and PAUSE is entered on a later cycle.
- **RUN.**
  - Each game counter counts 0..P-1. At the edge where it equals P-1 it wraps to 0 and sets its tick register, so the tick is high for exactly one cycle.
  - pause=1 moves to PAUSE.
- **PAUSE.**
  - All game and cooldown counters hold their value. Ticks and fire_grant stay 0 and fire_req is ignored. cooldown_busy keeps its value.
  - pause=0 returns to RUN, and counting resumes from the held counts.
- **Return to IDLE.** Only reset returns the block to IDLE.
- **Alien period.**
  - Period = ALIEN_BASE_PERIOD - level*ALIEN_STEP.
  - It is recomputed only on IDLE->RUN and at each alien wrap. A level change mid-period takes effect from the next period.
- **Fire arbitration.** Applies only in RUN.
  - At an edge with fire_req=1 and cooldown_busy=0: fire_grant<=1, cooldown_busy<=1, cd_cnt<=0.
  - While busy: cd_cnt increments each RUN cycle. At the edge where cd_cnt==COOLDOWN_PERIOD-1, busy<=0.
  - A request made while busy is dropped, not queued.
- **pix_en.**
  - A 2-bit counter, free-running in every state. pix_en is registered high the cycle after the count reaches 3.
- **Arithmetic.**
  - Counters are $clog2(max period) bits wide, with no overflow beyond P-1.
  - level*ALIEN_STEP is computed at full width.

## Timing
- All outputs are registered and there are no combinational input-to-output paths.
- The first tick_x is visible P cycles after state first reads RUN.
- Subsequent tick_x strobes are exactly P RUN-cycles apart. Paused cycles do not count.
- fire_grant is visible 1 cycle after fire_req is sampled. cooldown_busy rises in the same cycle as fire_grant.
- With fire_req held high continuously in RUN, grants are spaced COOLDOWN_PERIOD+1 cycles apart.
- The state change is visible 1 cycle after start or pause is sampled.
- Reset asserted mid-operation: outputs go to 0 immediately and asynchronously. Reset release is synchronous to master_clk.

## Structure
- **Package tick_pkg:**
  - state enum (IDLE/RUN/PAUSE, 2-bit encodings)
  - default period constants
  - LEVEL_W
- **Sub-module tick_counter**, parameterised on counter width. It is instantiated three times (ship, projectile, alien); the cooldown counter is kept in the top level.
  - Inputs: period, enable, clear.
  - Output: registered wrap strobe.
- The FSM, fire arbitration and pix_en counter live in the top level.

## Test plan
Bench parameters: SHIP_PERIOD=10, PROJ_PERIOD=50, ALIEN_BASE_PERIOD=64, ALIEN_STEP=8, COOLDOWN_PERIOD=20.

1. **Reset and IDLE.** Assert reset for 3 cycles, then wait 100 cycles without start. Required: all outputs 0 and state=00 throughout, except pix_en pulsing every 4th cycle.
2. **Tick spacing.** Pulse start with level=0 and run 200 cycles. Required:
   - tick_ship: 20 pulses, 10 apart.
   - tick_proj: 4 pulses, 50 apart.
   - tick_alien: 3 pulses, 64 apart.
3. **Pause and resume.** In RUN, hold pause for 37 cycles midway through a ship period. Required: no ticks during the pause, and the next tick_ship arrives after the remaining count with 37 cycles of added delay. state reads 10 for the duration.
4. **Level change.** Set level=3 mid-period. Required: the current alien interval is still 64, and the following intervals are 40.
5. **Fire cooldown.** Hold fire_req high in RUN for 60 cycles. Required: grants on cycles 1, 22 and 43 relative to the first sample. cooldown_busy is high 20 cycles after each grant.
6. **Reset mid-cooldown.** Apply reset during a cooldown in PAUSE. Required: everything clears immediately, state=IDLE, and a fire_req after restart is granted on the first RUN cycle.
